// File: rtl/executs_muldiv_if.sv
// HI/LO-group handshake between the pipeline and the mult/div unit.
// Master is the pipeline side; slave is executs_muldiv.
interface executs_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Md_en;
  logic [5:0]       Function_opcode;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             Hilo_read;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Md_busy;
  logic             Md_done;
  logic             Stall;

  modport master (
    output Md_en, Function_opcode,
    output Read_data_1, Read_data_2,
    output Hilo_read,
    input  Hi, Lo, Md_busy, Md_done, Stall
  );

  modport slave (
    input  Md_en, Function_opcode,
    input  Read_data_1, Read_data_2,
    input  Hilo_read,
    output Hi, Lo, Md_busy, Md_done, Stall
  );
endinterface

// File: rtl/executs_muldiv.sv
// Iterative MIPS mult/div unit with HI/LO registers.
// Divider is built only when MULDIV_DIV_EN is defined.
module executs_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clock,
  input logic           reset,
  executs_muldiv_if.slave bus
);
  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
`ifdef MULDIV_DIV_EN
    S_DIV,
`endif
    S_FIX
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_acc;
  logic [W-1:0]     r_opd;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic             r_sa;
  logic             r_sb;
  logic             r_done;

  logic [5:0]     w_f;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic           w_sgn;
  logic           w_sa;
  logic           w_sb;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic           w_busy;
  logic           w_mul_go;
  logic           w_mthi;
  logic           w_mtlo;
  logic [W:0]     w_sum;
  logic [2*W-1:0] w_mul_nxt;
  logic [2*W-1:0] w_prod;

  assign w_f      = bus.Function_opcode;
  assign w_a      = bus.Read_data_1;
  assign w_b      = bus.Read_data_2;
  // funct bit 0 clear selects the signed variant
  assign w_sgn    = ~w_f[0];
  assign w_sa     = w_sgn & w_a[W-1];
  assign w_sb     = w_sgn & w_b[W-1];
  assign w_abs_a  = w_sa ? -w_a : w_a;
  assign w_abs_b  = w_sb ? -w_b : w_b;
  assign w_busy   = (r_state != S_IDLE);
  assign w_mul_go = bus.Md_en &
                    ((w_f == 6'b011000) | (w_f == 6'b011001));
  assign w_mthi   = bus.Md_en & (w_f == 6'b010001);
  assign w_mtlo   = bus.Md_en & (w_f == 6'b010011);

  // shift-add: low half holds the multiplier, consumed LSB first
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} +
                     (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_nxt = {w_sum, r_acc[W-1:1]};
  assign w_prod    = (r_sa ^ r_sb) ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
  logic           r_div;
  logic           r_dz;
  logic           w_div_go;
  logic [W:0]     w_sh;
  logic [W:0]     w_diff;
  logic           w_ge;
  logic [2*W-1:0] w_div_nxt;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;

  assign w_div_go  = bus.Md_en &
                     ((w_f == 6'b011010) | (w_f == 6'b011011));
  // restoring step: upper half is remainder, lower half quotient
  assign w_sh      = r_acc[2*W-1:W-1];
  assign w_diff    = w_sh - {1'b0, r_opd};
  assign w_ge      = ~w_diff[W];
  assign w_div_nxt = {w_ge ? w_diff[W-1:0] : w_sh[W-1:0],
                      r_acc[W-2:0], w_ge};
  // with a zero divisor the remainder ends as |rs|, so sign fix restores rs
  assign w_quo     = r_dz ? '1 :
                     ((r_sa ^ r_sb) ? -r_acc[W-1:0] : r_acc[W-1:0]);
  assign w_rem     = r_sa ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opd   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_done  <= 1'b0;
`ifdef MULDIV_DIV_EN
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_mul_go) begin
            r_state <= S_MUL;
            r_cnt   <= CNT_W'(W - 1);
            r_opd   <= w_abs_a;
            r_acc   <= {{W{1'b0}}, w_abs_b};
            r_sa    <= w_sa;
            r_sb    <= w_sb;
`ifdef MULDIV_DIV_EN
            r_div   <= 1'b0;
            r_dz    <= 1'b0;
          end else if (w_div_go) begin
            r_state <= S_DIV;
            r_cnt   <= CNT_W'(W - 1);
            r_opd   <= w_abs_b;
            r_acc   <= {{W{1'b0}}, w_abs_a};
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_div   <= 1'b1;
            r_dz    <= (w_b == '0);
`endif
          end else if (w_mthi) begin
            r_hi <= w_a;
          end else if (w_mtlo) begin
            r_lo <= w_a;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          if (r_cnt == '0) r_state <= S_FIX;
          else r_cnt <= r_cnt - 1'b1;
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          r_acc <= w_div_nxt;
          if (r_cnt == '0) r_state <= S_FIX;
          else r_cnt <= r_cnt - 1'b1;
        end
`endif
        S_FIX: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
`ifdef MULDIV_DIV_EN
          if (r_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else
`endif
          begin
            r_hi <= w_prod[2*W-1:W];
            r_lo <= w_prod[W-1:0];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Hi      = r_hi;
  assign bus.Lo      = r_lo;
  assign bus.Md_busy = w_busy;
  assign bus.Md_done = r_done;
  assign bus.Stall   = w_busy & (bus.Md_en | bus.Hilo_read);
endmodule

// File: tb/tb_executs_muldiv.sv
// Bench for executs_muldiv: arithmetic reference model plus
// directed vectors with hand-computed HI/LO values.
module tb_executs_muldiv;
  localparam int W = 32;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic chk_on = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  executs_muldiv_if #(.WIDTH(W)) bus ();

  executs_muldiv #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic is_start(input logic [5:0] f);
`ifdef MULDIV_DIV_EN
    return f == F_MULT || f == F_MULTU ||
           f == F_DIV || f == F_DIVU;
`else
    return f == F_MULT || f == F_MULTU;
`endif
  endfunction

  // {HI,LO} straight from integer arithmetic
  function automatic logic [2*W-1:0] ref_op(input logic [5:0] f,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa;
    longint sb;
    logic [2*W-1:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (f)
      F_MULT:  r = sa * sb;
      F_MULTU: r = {32'b0, a} * {32'b0, b};
      F_DIV:
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {32'(sa % sb), 32'(sa / sb)};
      F_DIVU:
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  int m_cnt;
  logic [W-1:0] m_hi, m_lo, m_phi, m_plo;
  logic m_done;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_phi  <= '0;
      m_plo  <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi   <= m_phi;
          m_lo   <= m_plo;
          m_done <= 1'b1;
        end
      end else if (bus.Md_en) begin
        if (is_start(bus.Function_opcode)) begin
          m_cnt <= W + 1;
          {m_phi, m_plo} <= ref_op(bus.Function_opcode,
                                   bus.Read_data_1,
                                   bus.Read_data_2);
        end else if (bus.Function_opcode == F_MTHI) begin
          m_hi <= bus.Read_data_1;
        end else if (bus.Function_opcode == F_MTLO) begin
          m_lo <= bus.Read_data_1;
        end
      end
    end
  end

  always begin
    @(posedge clock);
    #3;
    if (chk_on) begin
      check("cyc_hi", bus.Hi, m_hi);
      check("cyc_lo", bus.Lo, m_lo);
      check("cyc_busy", {31'b0, bus.Md_busy}, {31'b0, m_cnt != 0});
      check("cyc_done", {31'b0, bus.Md_done}, {31'b0, m_done});
      check("cyc_stall", {31'b0, bus.Stall},
            {31'b0, (m_cnt != 0) &&
                    (bus.Md_en || bus.Hilo_read)});
    end
  end

  // hold the instruction while stalled; hs/ls seen when it issues
  task automatic issue(input logic [5:0] f,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic en,
                       input logic rd,
                       output int stalls,
                       output logic [W-1:0] hs,
                       output logic [W-1:0] ls);
    @(negedge clock);
    bus.Md_en = en;
    bus.Hilo_read = rd;
    bus.Function_opcode = f;
    bus.Read_data_1 = a;
    bus.Read_data_2 = b;
    stalls = 0;
    #1;
    while (bus.Stall && stalls < 100) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    if (bus.Stall) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: stall still %b after %0d cycles",
               bus.Stall, stalls);
    end
    hs = bus.Hi;
    ls = bus.Lo;
    @(negedge clock);
    bus.Md_en = 1'b0;
    bus.Hilo_read = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] f,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output int nb,
                        output int nd);
    int s;
    logic [W-1:0] hs, ls;
    issue(f, a, b, 1'b1, 1'b0, s, hs, ls);
    nb = 0;
    nd = 0;
    repeat (40) begin
      #1;
      nb += int'(bus.Md_busy);
      nd += int'(bus.Md_done);
      @(negedge clock);
    end
  endtask

  initial begin
    int nb, nd, s;
    logic [W-1:0] hs, ls;
    logic [5:0] rst_op;
    bus.Md_en = 1'b0;
    bus.Hilo_read = 1'b0;
    bus.Function_opcode = '0;
    bus.Read_data_1 = '0;
    bus.Read_data_2 = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_on = 1'b1;
    #1;
    check("rst_hi", bus.Hi, 0);
    check("rst_lo", bus.Lo, 0);
    check("rst_busy", {31'b0, bus.Md_busy}, 0);
    check("rst_done", {31'b0, bus.Md_done}, 0);
    check("rst_stall", {31'b0, bus.Stall}, 0);

    run_op(F_MULT, -3, 5, nb, nd);
    check("mult_busy_cycles", nb, 33);
    check("mult_done_cycles", nd, 1);
    check("mult_hi", bus.Hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.Lo, 32'hFFFF_FFF1);

    run_op(F_MULT, 32'h7FFF_FFFF, 32'h8000_0000, nb, nd);
    check("mult_big_hi", bus.Hi, 32'hC000_0000);
    check("mult_big_lo", bus.Lo, 32'h8000_0000);

    run_op(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, nb, nd);

`ifdef MULDIV_DIV_EN
    run_op(F_DIVU, 100, 7, nb, nd);
    check("divu_lo", bus.Lo, 14);
    check("divu_hi", bus.Hi, 2);
    run_op(F_DIV, -7, 2, nb, nd);
    check("div_neg_lo", bus.Lo, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.Hi, 32'hFFFF_FFFF);
    run_op(F_DIV, 7, -2, nb, nd);
    check("div_nd_lo", bus.Lo, 32'hFFFF_FFFD);
    check("div_nd_hi", bus.Hi, 1);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
    check("div_ovf_lo", bus.Lo, 32'h8000_0000);
    check("div_ovf_hi", bus.Hi, 0);
    run_op(F_DIV, 1234, 0, nb, nd);
    check("div0_busy_cycles", nb, 33);
    check("div0_lo", bus.Lo, 32'hFFFF_FFFF);
    check("div0_hi", bus.Hi, 1234);
    run_op(F_DIV, -1234, 0, nb, nd);
    check("div0n_hi", bus.Hi, -1234);
    run_op(F_DIVU, 32'hFFFF_FFFF, 32'h10, nb, nd);
    check("divu_big_lo", bus.Lo, 32'h0FFF_FFFF);
    check("divu_big_hi", bus.Hi, 32'hF);
    rst_op = F_DIV;
`else
    issue(F_DIV, 100, 7, 1'b1, 1'b0, s, hs, ls);
    check("nodiv_stall", s, 0);
    run_op(F_DIVU, 100, 7, nb, nd);
    check("nodiv_busy", nb, 0);
    check("nodiv_done", nd, 0);
    run_op(F_MULT, 32'h7FFF_FFFF, 32'h8000_0000, nb, nd);
    run_op(F_DIV, 9, 3, nb, nd);
    check("nodiv_hi", bus.Hi, 32'hC000_0000);
    check("nodiv_lo", bus.Lo, 32'h8000_0000);
    rst_op = F_MULT;
`endif

    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          1'b1, 1'b0, s, hs, ls);
    repeat (4) @(negedge clock);
    issue(F_MFLO, 0, 0, 1'b1, 1'b1, s, hs, ls);
    check("mflo_stall_cycles", s, 28);
    check("mflo_sees_lo", ls, 1);
    check("multu_hi", hs, 32'hFFFF_FFFE);

    issue(F_MTHI, 32'hA5A5_A5A5, 0, 1'b1, 1'b0, s, hs, ls);
    check("mthi_before", hs, 32'hFFFF_FFFE);
    #1;
    check("mthi_hi", bus.Hi, 32'hA5A5_A5A5);
    check("mthi_lo", bus.Lo, 1);
    check("mthi_busy", {31'b0, bus.Md_busy}, 0);

    issue(F_MULT, 3, 4, 1'b1, 1'b0, s, hs, ls);
    repeat (3) @(negedge clock);
    issue(F_MTHI, 32'h1234_5678, 0, 1'b1, 1'b0, s, hs, ls);
    check("mthi_mid_prior_hi", hs, 0);
    check("mthi_mid_prior_lo", ls, 12);
    #1;
    check("mthi_mid_hi", bus.Hi, 32'h1234_5678);
    check("mthi_mid_lo", bus.Lo, 12);

    issue(F_MULTU, 10, 20, 1'b1, 1'b0, s, hs, ls);
    issue(F_MULT, -1, -1, 1'b1, 1'b0, s, hs, ls);
    check("b2b_stall_cycles", s, 32);
    check("b2b_first_lo", ls, 200);
    repeat (40) @(negedge clock);
    check("b2b_hi", bus.Hi, 0);
    check("b2b_lo", bus.Lo, 1);

    issue(rst_op, 1000, 3, 1'b1, 1'b0, s, hs, ls);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_hi", bus.Hi, 0);
    check("abort_lo", bus.Lo, 0);
    check("abort_busy", {31'b0, bus.Md_busy}, 0);
    nd = 0;
    repeat (40) begin
      @(negedge clock);
      #1;
      nd += int'(bus.Md_done);
    end
    check("abort_no_done", nd, 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
